// File: rtl/sram_port_arbiter_if.sv
// Request/response handshake between the record/play sequencers and the SRAM arbiter.
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic              WR_REQ;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [DATA_W-1:0] WR_DATA;
   logic              WR_ACK;
   logic              RD_REQ;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [DATA_W-1:0] RD_DATA;
   logic              RD_VALID;
   logic              BUSY;

   modport master (
      output WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR,
      input  WR_ACK, RD_DATA, RD_VALID, BUSY
   );

   modport slave (
      input  WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR,
      output WR_ACK, RD_DATA, RD_VALID, BUSY
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a write (record) port
// and a read (playback) port; all SRAM pins and handshake outputs are registered.
module sram_port_arbiter #(
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 16,
   parameter int ACC_CYC = 2
) (
   input  logic                  CLK50,
   input  logic                  RST,
   sram_port_arbiter_if.slave    host,
   output logic [ADDR_W-1:0]     SRAM_ADDR,
   inout  wire  [DATA_W-1:0]     SRAM_DATA,
   output logic                  SRAM_CE,
   output logic                  SRAM_OE,
   output logic                  SRAM_WE,
   output logic                  SRAM_UB,
   output logic                  SRAM_LB
);

   typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_e;
   typedef enum logic {PORT_WR, PORT_RD} port_e;

   localparam logic [2:0] LAST_CNT = 3'(ACC_CYC - 1);

   state_e            state, state_n;
   port_e             op, op_n, last;
   logic [2:0]        cnt, cnt_n;
   logic              grant, acc_done, wr_done, rd_done;
   logic              wr_pend, rd_pend;
   logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
   logic [DATA_W-1:0] wr_data_q, dout_q;
   logic              drive;

   always_comb begin
      state_n  = state;
      op_n     = op;
      cnt_n    = cnt;
      grant    = 1'b0;
      acc_done = 1'b0;
      case (state)
         IDLE: begin
            if (wr_pend || rd_pend) begin
               grant   = 1'b1;
               state_n = ACCESS;
               cnt_n   = '0;
               // on contention the port not served last wins
               if (wr_pend && (!rd_pend || last == PORT_RD)) op_n = PORT_WR;
               else                                          op_n = PORT_RD;
            end
         end
         ACCESS: begin
            if (cnt == LAST_CNT) begin
               acc_done = 1'b1;
               state_n  = TURN;
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         TURN:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      wr_done = (state == TURN) && (op == PORT_WR);
      rd_done = (state == TURN) && (op == PORT_RD);
   end

   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         op    <= PORT_WR;
         last  <= PORT_RD;
         cnt   <= '0;
      end else begin
         state <= state_n;
         op    <= op_n;
         cnt   <= cnt_n;
         if (grant) last <= op_n;
      end
   end

   // a new pulse coinciding with the completion of the same port is kept
   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         wr_pend   <= 1'b0;
         rd_pend   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
      end else begin
         if (host.WR_REQ && (!wr_pend || wr_done)) begin
            wr_pend   <= 1'b1;
            wr_addr_q <= host.WR_ADDR;
            wr_data_q <= host.WR_DATA;
         end else if (wr_done) begin
            wr_pend <= 1'b0;
         end
         if (host.RD_REQ && (!rd_pend || rd_done)) begin
            rd_pend   <= 1'b1;
            rd_addr_q <= host.RD_ADDR;
         end else if (rd_done) begin
            rd_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         SRAM_ADDR     <= '0;
         SRAM_CE       <= 1'b1;
         SRAM_OE       <= 1'b1;
         SRAM_WE       <= 1'b1;
         SRAM_UB       <= 1'b1;
         SRAM_LB       <= 1'b1;
         drive         <= 1'b0;
         dout_q        <= '0;
         host.WR_ACK   <= 1'b0;
         host.RD_VALID <= 1'b0;
         host.RD_DATA  <= '0;
         host.BUSY     <= 1'b0;
      end else begin
         if (grant) begin
            SRAM_ADDR <= (op_n == PORT_WR) ? wr_addr_q : rd_addr_q;
            dout_q    <= wr_data_q;
         end
         SRAM_CE       <= (state_n != ACCESS);
         SRAM_UB       <= (state_n != ACCESS);
         SRAM_LB       <= (state_n != ACCESS);
         SRAM_WE       <= !((state_n == ACCESS) && (op_n == PORT_WR));
         SRAM_OE       <= !((state_n == ACCESS) && (op_n == PORT_RD));
         drive         <= (state_n == ACCESS) && (op_n == PORT_WR);
         host.WR_ACK   <= acc_done && (op == PORT_WR);
         host.RD_VALID <= acc_done && (op == PORT_RD);
         if (acc_done && (op == PORT_RD)) host.RD_DATA <= SRAM_DATA;
         host.BUSY     <= (state_n != IDLE);
      end
   end

   assign SRAM_DATA = drive ? dout_q : 'z;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural async SRAM and bus keeper.
module tb_sram_port_arbiter;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam logic [15:0] KEEP = 16'hA5A5;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] sram_addr;
   wire  [DATA_W-1:0] sram_data;
   logic              sram_ce, sram_oe, sram_we, sram_ub, sram_lb;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic              pre_en;
   logic [ADDR_W-1:0] pre_addr;
   logic [DATA_W-1:0] pre_data;

   int ncomp = 0;
   int nfail = 0;
   int acks;

   sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

   sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(2)) dut (
      .CLK50     (clk),
      .RST       (rst),
      .host      (host),
      .SRAM_ADDR (sram_addr),
      .SRAM_DATA (sram_data),
      .SRAM_CE   (sram_ce),
      .SRAM_OE   (sram_oe),
      .SRAM_WE   (sram_we),
      .SRAM_UB   (sram_ub),
      .SRAM_LB   (sram_lb)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // SRAM read data when enabled, otherwise a keeper pattern whenever the arbiter must not drive
   assign sram_data = sram_we ? ((!sram_ce && !sram_oe) ? mem[sram_addr] : KEEP) : 'z;

   always @(posedge clk) begin
      if (pre_en)                   mem[pre_addr]  <= pre_data;
      else if (!sram_ce && !sram_we) mem[sram_addr] <= sram_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ncomp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      host.WR_REQ = 1'b0; host.WR_ADDR = '0; host.WR_DATA = '0;
      host.RD_REQ = 1'b0; host.RD_ADDR = '0;
      pre_en = 1'b1; pre_addr = 18'h3FFFF; pre_data = 16'h1234;
      cyc();
      cyc();
      pre_en = 1'b0;

      // reset values
      chk("rst_ce",   32'(sram_ce), 32'd1);
      chk("rst_oe",   32'(sram_oe), 32'd1);
      chk("rst_we",   32'(sram_we), 32'd1);
      chk("rst_ublb", 32'({sram_ub, sram_lb}), 32'd3);
      chk("rst_bus",  32'(sram_data), 32'(KEEP));
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_rdd",  32'(host.RD_DATA), 32'd0);
      chk("rst_flags", 32'({host.WR_ACK, host.RD_VALID, host.BUSY}), 32'd0);
      rst = 1'b0;

      // single write
      cyc();
      host.WR_ADDR = 18'h00010; host.WR_DATA = 16'hBEEF; host.WR_REQ = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         host.WR_REQ = 1'b0;
         chk("wr_we",   32'(sram_we), 32'((c == 2 || c == 3) ? 1 : 0) ^ 32'd1);
         chk("wr_ack",  32'(host.WR_ACK), 32'(c == 4));
         chk("wr_busy", 32'(host.BUSY), 32'(c >= 2 && c <= 4));
         if (c == 2 || c == 3) begin
            chk("wr_bus",  32'(sram_data), 32'h0000BEEF);
            chk("wr_addr", 32'(sram_addr), 32'h00010);
            chk("wr_ce",   32'(sram_ce), 32'd0);
            chk("wr_oe",   32'(sram_oe), 32'd1);
         end
         if (c == 4) chk("wr_turn_bus", 32'(sram_data), 32'(KEEP));
      end
      chk("wr_mem", 32'(mem[18'h00010]), 32'h0000BEEF);

      // single read
      cyc();
      host.RD_ADDR = 18'h3FFFF; host.RD_REQ = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         host.RD_REQ = 1'b0;
         chk("rd_oe",    32'(sram_oe), 32'(!(c == 2 || c == 3)));
         chk("rd_we",    32'(sram_we), 32'd1);
         chk("rd_valid", 32'(host.RD_VALID), 32'(c == 4));
         if (c == 2) chk("rd_bus", 32'(sram_data), 32'h00001234);
         if (c >= 4) chk("rd_data", 32'(host.RD_DATA), 32'h00001234);
      end

      // contention from reset, both ports re-pulsed on their completions
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      cyc();
      host.WR_ADDR = 18'h00020; host.WR_DATA = 16'h1111; host.WR_REQ = 1'b1;
      host.RD_ADDR = 18'h00010; host.RD_REQ = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         cyc();
         host.WR_REQ = (c == 4);
         host.RD_REQ = (c == 8);
         if (c == 4) begin host.WR_ADDR = 18'h00021; host.WR_DATA = 16'h2222; end
         if (c == 8) host.RD_ADDR = 18'h00020;
         chk("cont_we",    32'(sram_we), 32'(!(c == 2 || c == 3 || c == 10 || c == 11)));
         chk("cont_oe",    32'(sram_oe), 32'(!(c == 6 || c == 7 || c == 14 || c == 15)));
         chk("cont_ack",   32'(host.WR_ACK), 32'(c == 4 || c == 12));
         chk("cont_valid", 32'(host.RD_VALID), 32'(c == 8 || c == 16));
         if (c == 8)  chk("cont_rd1", 32'(host.RD_DATA), 32'h0000BEEF);
         if (c == 16) chk("cont_rd2", 32'(host.RD_DATA), 32'h00001111);
      end
      chk("cont_mem", 32'(mem[18'h00021]), 32'h00002222);

      // duplicate write pulse while pending
      cyc();
      host.WR_ADDR = 18'h00030; host.WR_DATA = 16'hAAAA; host.WR_REQ = 1'b1;
      acks = 0;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         host.WR_REQ = (c == 1);
         if (c == 1) begin host.WR_ADDR = 18'h00031; host.WR_DATA = 16'h5555; end
         if (c == 2) begin
            chk("dup_addr", 32'(sram_addr), 32'h00030);
            chk("dup_bus",  32'(sram_data), 32'h0000AAAA);
         end
         if (host.WR_ACK) acks++;
      end
      chk("dup_acks", 32'(acks), 32'd1);
      chk("dup_mem",  32'(mem[18'h00030]), 32'h0000AAAA);

      // read re-requested in its own completion cycle
      cyc();
      host.RD_ADDR = 18'h00030; host.RD_REQ = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         host.RD_REQ = (c == 4);
         if (c == 4) host.RD_ADDR = 18'h00010;
         chk("rr_oe",    32'(sram_oe), 32'(!(c == 2 || c == 3 || c == 6 || c == 7)));
         chk("rr_valid", 32'(host.RD_VALID), 32'(c == 4 || c == 8));
         if (c == 4) chk("rr_data1", 32'(host.RD_DATA), 32'h0000AAAA);
         if (c == 8) chk("rr_data2", 32'(host.RD_DATA), 32'h0000BEEF);
      end

      // asynchronous reset in the second write ACCESS cycle
      cyc();
      host.WR_ADDR = 18'h00040; host.WR_DATA = 16'h7777; host.WR_REQ = 1'b1;
      cyc(); host.WR_REQ = 1'b0;
      cyc();
      cyc();
      chk("ar_we_pre", 32'(sram_we), 32'd0);
      #4 rst = 1'b1;
      #1;
      chk("ar_we",   32'(sram_we), 32'd1);
      chk("ar_ce",   32'(sram_ce), 32'd1);
      chk("ar_bus",  32'(sram_data), 32'(KEEP));
      chk("ar_busy", 32'(host.BUSY), 32'd0);
      cyc(); rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         chk("ar_noack", 32'(host.WR_ACK), 32'd0);
         chk("ar_idle",  32'(host.BUSY), 32'd0);
      end
      cyc();
      host.RD_ADDR = 18'h3FFFF; host.RD_REQ = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         host.RD_REQ = 1'b0;
         chk("ar_rd_valid", 32'(host.RD_VALID), 32'(c == 4));
         if (c == 4) chk("ar_rd_data", 32'(host.RD_DATA), 32'h00001234);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
